spi_byte_sequencer: RTL and testbench

Upstream feeder and downstream collector for the SPI master. Accepts a byte stream over valid/ready, packs up to four bytes into one SPI master transfer word, drives the master's enable/write-data/bytes-valid inputs, waits until the master reports the same number of received bytes, and clears its fill level. It then returns the received bytes as a byte stream over valid/ready.

---
 rtl/spi_seq_pkg.sv | 25 ++
 rtl/spi_seq_timer.sv | 39 +++
 rtl/spi_byte_sequencer.sv | 175 +++++++++++++++++
 tb/tb_spi_byte_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI byte sequencer: FSM states, the
// four-byte word layout and the timer width.
package spi_seq_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_W        = 3;
  localparam int TIMER_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LAUNCH,
    ST_WAIT,
    ST_CLEAR,
    ST_DRAIN
  } state_e;

  // Byte k of a word occupies bits [8k+7:8k]; byte 0 goes on the wire first.
  typedef logic [BYTES_PER_WORD-1:0][7:0] word_t;

  function automatic logic [7:0] byte_at(input word_t w, input logic [1:0] idx);
    return w[idx];
  endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Cycle counter with synchronous clear and enable; expire_o flags the
// enabled cycle on which the running count reaches limit_i.
module spi_seq_timer
  import spi_seq_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic [TIMER_W-1:0] limit_i,
  output logic               expire_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // A clear that coincides with an enabled cycle counts that cycle as the first.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = enable_i ? TIMER_W'(1) : '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  assign expire_o = enable_i &&
                    (({1'b0, cnt_q} + (TIMER_W + 1)'(1)) >= {1'b0, limit_i});

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of process order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Packs up to four tx bytes into one SPI master transfer, waits for the master
// to report the same receive fill level, clears it, and streams the rx bytes.
module spi_byte_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter int unsigned WAIT_CYCLES  = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  tx_byte_i,
  input  logic        tx_valid_i,
  input  logic        tx_last_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_byte_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        spi_enable_o,
  output logic [31:0] spi_write_data_o,
  output logic [2:0]  spi_write_data_bytes_valid_o,
  output logic        spi_reset_fill_level_o,
  input  logic [31:0] spi_read_data_i,
  input  logic [2:0]  spi_read_data_bytes_valid_i,
  output logic        busy_o,
  output logic        timeout_o
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  word_t              slots_q, slots_d;
  word_t              rx_q, rx_d;
  logic               rx_empty_q, rx_empty_d;
  logic               timeout_q, timeout_d;

  logic tx_accept;
  logic match;
  logic flush_clear, flush_enable, flush_expire;
  logic wait_clear, wait_enable, wait_expire;

  assign tx_ready_o = !rst_i &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_FILL) && (count_q < COUNT_W'(BYTES_PER_WORD))));
  assign tx_accept  = tx_valid_i && tx_ready_o;
  assign match      = (state_q == ST_WAIT) && (spi_read_data_bytes_valid_i == count_q);

  // Flush timer restarts on every accepted byte and only runs while filling.
  assign flush_clear  = tx_accept || (state_q != ST_FILL);
  assign flush_enable = tx_accept || (state_q == ST_FILL);
  assign wait_clear   = (state_q != ST_WAIT);
  assign wait_enable  = (state_q == ST_WAIT);

  spi_seq_timer u_flush_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (flush_clear),
    .enable_i (flush_enable),
    .limit_i  (TIMER_W'(FLUSH_CYCLES)),
    .expire_o (flush_expire)
  );

  spi_seq_timer u_wait_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (wait_clear),
    .enable_i (wait_enable),
    .limit_i  (TIMER_W'(WAIT_CYCLES)),
    .expire_o (wait_expire)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    slots_d    = slots_q;
    rx_d       = rx_q;
    rx_empty_d = rx_empty_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        count_d = '0;
        idx_d   = '0;
        slots_d = '0;
        if (tx_accept) begin
          slots_d[0] = tx_byte_i;
          count_d    = COUNT_W'(1);
          state_d    = tx_last_i ? ST_LAUNCH : ST_FILL;
        end
      end

      ST_FILL: begin
        if (tx_accept) begin
          slots_d[count_q[1:0]] = tx_byte_i;
          count_d               = count_q + COUNT_W'(1);
        end
        // An accept coinciding with flush expiry is stored before launching.
        if ((tx_accept && (tx_last_i || (count_q == COUNT_W'(BYTES_PER_WORD - 1)))) ||
            flush_expire) begin
          state_d = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (match) begin
          rx_d       = word_t'(spi_read_data_i);
          rx_empty_d = 1'b0;
          state_d    = ST_CLEAR;
        end else if (wait_expire) begin
          timeout_d  = 1'b1;
          rx_empty_d = 1'b1;
          state_d    = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        idx_d   = '0;
        state_d = rx_empty_q ? ST_IDLE : ST_DRAIN;
      end

      ST_DRAIN: begin
        if (rx_ready_i) begin
          if (idx_q == (count_q - COUNT_W'(1))) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + COUNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the byte slots and rx word are a handful of flops, not a RAM, so they
  // are reset along with the control state and a mid-transfer reset discards them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      slots_q    <= '0;
      rx_q       <= '0;
      rx_empty_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      slots_q    <= slots_d;
      rx_q       <= rx_d;
      rx_empty_q <= rx_empty_d;
      timeout_q  <= timeout_d;
    end
  end

  // Slots and count are frozen from LAUNCH through CLEAR, holding the word stable.
  assign spi_enable_o                 = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign spi_write_data_o             = slots_q;
  assign spi_write_data_bytes_valid_o = count_q;
  assign spi_reset_fill_level_o       = (state_q == ST_CLEAR);
  assign rx_valid_o                   = (state_q == ST_DRAIN);
  assign rx_byte_o                    = byte_at(rx_q, idx_q[1:0]);
  assign busy_o                       = (state_q != ST_IDLE);
  assign timeout_o                    = timeout_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with an echoing SPI master model that
// reports its fill level four cycles after enable rises.
module tb_spi_byte_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  tx_byte_i;
  logic        tx_valid_i;
  logic        tx_last_i;
  logic        tx_ready_o;
  logic [7:0]  rx_byte_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        spi_enable_o;
  logic [31:0] spi_write_data_o;
  logic [2:0]  spi_write_data_bytes_valid_o;
  logic        spi_reset_fill_level_o;
  logic [31:0] spi_read_data_i;
  logic [2:0]  spi_read_data_bytes_valid_i;
  logic        busy_o;
  logic        timeout_o;

  int checks      = 0;
  int errors      = 0;
  int fill_pulses = 0;
  bit echo_en     = 1'b1;

  logic [2:0]  m_cnt = '0;
  logic [2:0]  m_bv  = '0;
  logic [31:0] m_rd  = '0;

  always #5 clk_i = ~clk_i;

  spi_byte_sequencer #(
    .FLUSH_CYCLES (16),
    .WAIT_CYCLES  (8)
  ) dut (
    .clk_i                        (clk_i),
    .rst_i                        (rst_i),
    .tx_byte_i                    (tx_byte_i),
    .tx_valid_i                   (tx_valid_i),
    .tx_last_i                    (tx_last_i),
    .tx_ready_o                   (tx_ready_o),
    .rx_byte_o                    (rx_byte_o),
    .rx_valid_o                   (rx_valid_o),
    .rx_ready_i                   (rx_ready_i),
    .spi_enable_o                 (spi_enable_o),
    .spi_write_data_o             (spi_write_data_o),
    .spi_write_data_bytes_valid_o (spi_write_data_bytes_valid_o),
    .spi_reset_fill_level_o       (spi_reset_fill_level_o),
    .spi_read_data_i              (spi_read_data_i),
    .spi_read_data_bytes_valid_i  (spi_read_data_bytes_valid_i),
    .busy_o                       (busy_o),
    .timeout_o                    (timeout_o)
  );

  assign spi_read_data_i             = m_rd;
  assign spi_read_data_bytes_valid_i = m_bv;

  // Master model: loops the write word back after enable has been high 4 cycles.
  always @(posedge clk_i) begin
    if (rst_i || spi_reset_fill_level_o) begin
      m_cnt <= '0;
      m_bv  <= '0;
      m_rd  <= '0;
    end else if (spi_enable_o && echo_en) begin
      if (m_cnt == 3'd3) begin
        m_bv <= spi_write_data_bytes_valid_o;
        m_rd <= spi_write_data_o;
      end else begin
        m_cnt <= m_cnt + 3'd1;
      end
    end
  end

  always @(posedge clk_i) begin
    if (spi_reset_fill_level_o === 1'b1) fill_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_tx();
    tx_valid_i = 1'b0;
    tx_last_i  = 1'b0;
    tx_byte_i  = 8'h00;
  endtask

  // Presents one byte at a falling edge; it is accepted on the next rising edge.
  task automatic send(input logic [7:0] b, input logic last, input string name);
    tx_byte_i  = b;
    tx_valid_i = 1'b1;
    tx_last_i  = last;
    checks++;
    if (tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b expected 1", name, tx_ready_o);
    end
    @(negedge clk_i);
  endtask

  // Called at the falling edge inside LAUNCH; follows the transfer back to IDLE.
  task automatic observe(input logic [31:0] exp_wd, input logic [2:0] exp_bv,
                         input bit exp_rx, input int exp_n, input int stall_idx,
                         input string name);
    int n;
    bit held_ok;
    bit stall_ok;
    checks++;
    if (spi_enable_o !== 1'b1 || spi_write_data_o !== exp_wd ||
        spi_write_data_bytes_valid_o !== exp_bv) begin
      errors++;
      $display("FAIL %s_launch: got en=%b wd=%h bv=%0d expected 1/%h/%0d",
               name, spi_enable_o, spi_write_data_o, spi_write_data_bytes_valid_o,
               exp_wd, exp_bv);
    end
    n = 0;
    held_ok = 1'b1;
    while (spi_reset_fill_level_o !== 1'b1 && n < 60) begin
      if (spi_enable_o !== 1'b1 || spi_write_data_o !== exp_wd ||
          spi_write_data_bytes_valid_o !== exp_bv || rx_valid_o !== 1'b0)
        held_ok = 1'b0;
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL %s_hold: got unstable enable/data during WAIT expected stable", name);
    end
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL %s_clear_latency: got %0d cycles expected %0d", name, n, exp_n);
    end
    checks++;
    if (spi_enable_o !== 1'b0 || spi_write_data_o !== exp_wd ||
        spi_write_data_bytes_valid_o !== exp_bv || timeout_o !== !exp_rx) begin
      errors++;
      $display("FAIL %s_clear: got en=%b wd=%h bv=%0d to=%b expected 0/%h/%0d/%b",
               name, spi_enable_o, spi_write_data_o, spi_write_data_bytes_valid_o,
               timeout_o, exp_wd, exp_bv, !exp_rx);
    end
    @(negedge clk_i);
    checks++;
    if (spi_reset_fill_level_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_single_pulse: got fill=%b to=%b expected 0/0",
               name, spi_reset_fill_level_o, timeout_o);
    end
    if (exp_rx) begin
      for (int i = 0; i < int'(exp_bv); i++) begin
        checks++;
        if (rx_valid_o !== 1'b1 || rx_byte_o !== exp_wd[8*i +: 8] || tx_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL %s_rx%0d: got valid=%b byte=%h ready=%b expected 1/%h/0",
                   name, i, rx_valid_o, rx_byte_o, tx_ready_o, exp_wd[8*i +: 8]);
        end
        if (i == stall_idx) begin
          rx_ready_i = 1'b0;
          stall_ok = 1'b1;
          repeat (5) begin
            @(negedge clk_i);
            if (rx_valid_o !== 1'b1 || rx_byte_o !== exp_wd[8*i +: 8] || tx_ready_o !== 1'b0)
              stall_ok = 1'b0;
          end
          checks++;
          if (!stall_ok) begin
            errors++;
            $display("FAIL %s_stall: got byte=%h valid=%b ready=%b expected %h/1/0",
                     name, rx_byte_o, rx_valid_o, tx_ready_o, exp_wd[8*i +: 8]);
          end
          rx_ready_i = 1'b1;
        end
        @(negedge clk_i);
      end
    end
    checks++;
    if (busy_o !== 1'b0 || rx_valid_o !== 1'b0 || tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: got busy=%b rx_valid=%b tx_ready=%b expected 0/0/1",
               name, busy_o, rx_valid_o, tx_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    rx_ready_i = 1'b1;
    idle_tx();
    repeat (3) @(negedge clk_i);
    checks++;
    if (tx_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx_ready: got %b expected 0", tx_ready_o);
    end
    checks++;
    if (busy_o !== 1'b0 || spi_enable_o !== 1'b0 || rx_valid_o !== 1'b0 ||
        spi_reset_fill_level_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b en=%b rxv=%b fill=%b to=%b expected all 0",
               busy_o, spi_enable_o, rx_valid_o, spi_reset_fill_level_o, timeout_o);
    end
    checks++;
    if (spi_write_data_o !== 32'h0 || spi_write_data_bytes_valid_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: got wd=%h bv=%0d expected 0/0",
               spi_write_data_o, spi_write_data_bytes_valid_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (tx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b expected 1/0", tx_ready_o, busy_o);
    end
  endtask

  task automatic test_full_word();
    send(8'h11, 1'b0, "full_b0");
    send(8'h22, 1'b0, "full_b1");
    send(8'h33, 1'b0, "full_b2");
    send(8'h44, 1'b0, "full_b3");
    idle_tx();
    checks++;
    if (tx_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_launch_ready: got %b expected 0", tx_ready_o);
    end
    observe(32'h44332211, 3'd4, 1'b1, 5, -1, "full");
  endtask

  task automatic test_last();
    send(8'hA5, 1'b0, "last_b0");
    send(8'h5A, 1'b1, "last_b1");
    idle_tx();
    observe(32'h00005AA5, 3'd2, 1'b1, 5, -1, "last");
  endtask

  task automatic test_flush();
    int n;
    send(8'h7E, 1'b0, "flush_b0");
    idle_tx();
    checks++;
    if (tx_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_fill: got ready=%b busy=%b expected 1/1", tx_ready_o, busy_o);
    end
    n = 1;
    while (spi_enable_o !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL flush_latency: got launch %0d cycles after accept expected 16", n);
    end
    observe(32'h0000007E, 3'd1, 1'b1, 5, -1, "flush");
  endtask

  task automatic test_flush_race();
    send(8'h01, 1'b0, "race_b0");
    idle_tx();
    repeat (14) @(negedge clk_i);
    checks++;
    if (spi_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL race_early: got enable=%b expected 0", spi_enable_o);
    end
    send(8'h02, 1'b0, "race_b1");
    idle_tx();
    observe(32'h00000201, 3'd2, 1'b1, 5, -1, "race");
  endtask

  task automatic test_timeout();
    int base;
    echo_en = 1'b0;
    base = fill_pulses;
    send(8'hC3, 1'b1, "timeout_b0");
    idle_tx();
    observe(32'h000000C3, 3'd1, 1'b0, 9, -1, "timeout");
    checks++;
    if (fill_pulses - base != 1) begin
      errors++;
      $display("FAIL timeout_fill_pulses: got %0d expected 1", fill_pulses - base);
    end
    echo_en = 1'b1;
  endtask

  task automatic test_drain_stall();
    send(8'hDE, 1'b0, "stall_b0");
    send(8'hAD, 1'b0, "stall_b1");
    send(8'hBE, 1'b0, "stall_b2");
    send(8'hEF, 1'b0, "stall_b3");
    idle_tx();
    observe(32'hEFBEADDE, 3'd4, 1'b1, 5, 2, "stall");
  endtask

  task automatic test_reset_in_wait();
    int base;
    base = fill_pulses;
    send(8'h99, 1'b1, "rstwait_b0");
    idle_tx();
    @(negedge clk_i);
    checks++;
    if (spi_enable_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_in_wait: got en=%b busy=%b expected 1/1", spi_enable_o, busy_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (spi_enable_o !== 1'b0 || busy_o !== 1'b0 || spi_reset_fill_level_o !== 1'b0 ||
        tx_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_idle: got en=%b busy=%b fill=%b ready=%b expected 0/0/0/0",
               spi_enable_o, busy_o, spi_reset_fill_level_o, tx_ready_o);
    end
    checks++;
    if (spi_write_data_o !== 32'h0 || spi_write_data_bytes_valid_o !== 3'd0) begin
      errors++;
      $display("FAIL rstwait_discard: got wd=%h bv=%0d expected 0/0",
               spi_write_data_o, spi_write_data_bytes_valid_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (tx_ready_o !== 1'b1 || rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_release: got ready=%b rx_valid=%b expected 1/0",
               tx_ready_o, rx_valid_o);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (fill_pulses != base || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_no_pulse: got pulses=%0d busy=%b expected 0/0",
               fill_pulses - base, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    send(8'h12, 1'b0, "b2b_b0");
    send(8'h34, 1'b1, "b2b_b1");
    idle_tx();
    observe(32'h00003412, 3'd2, 1'b1, 5, -1, "b2b_first");
    send(8'h56, 1'b1, "b2b_b2");
    idle_tx();
    observe(32'h00000056, 3'd1, 1'b1, 5, -1, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_last();
    test_flush();
    test_flush_race();
    test_timeout();
    test_drain_stall();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
